// File: rtl/comp_serial_cmp_pkg.sv
// Shared definitions for the serial 65-bit extended-operand comparator.
package comp_serial_cmp_pkg;

   localparam int DW_DEFAULT = 64;
   localparam int CW_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Extension bit placed above the operand MSB: sign copy for a signed
   // compare (ext=0), zero for an unsigned compare (ext=1).
   function automatic logic ext_msb(input logic msb, input logic ext);
      return ~ext & msb;
   endfunction

endpackage

// File: rtl/comp_serial_cmp_chunk_cmp.sv
// Combinational magnitude compare of two W-bit chunks. With signed_top_i set
// the chunks are two's complement, otherwise unsigned.
module comp_chunk_cmp #(
   parameter int W = 17
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         signed_top_i,
   output logic         lt_o,
   output logic         eq_o,
   output logic         gt_o
);

   logic [W-1:0] ka;
   logic [W-1:0] kb;

   // Flipping the MSB maps two's complement order onto unsigned order.
   always_comb begin
      ka   = {a_i[W-1] ^ signed_top_i, a_i[W-2:0]};
      kb   = {b_i[W-1] ^ signed_top_i, b_i[W-2:0]};
      lt_o = (ka < kb);
      eq_o = (ka == kb);
      gt_o = (ka > kb);
   end

endmodule

// File: rtl/comp_serial_cmp.sv
// Serial comparator: extends both operands to DW+1 bits, then compares one
// chunk per cycle from the most-significant chunk down, stopping at the
// first chunk that differs.
module comp_serial_cmp
   import comp_serial_cmp_pkg::*;
#(
   parameter int DW = DW_DEFAULT,
   parameter int CW = CW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic          ext,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          lt,
   output logic          eq,
   output logic          gt
);

   localparam int NCHUNK = DW / CW;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   state_t        state_q, state_d;
   logic [DW:0]   xa_q, xa_d;
   logic [DW:0]   xb_q, xb_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          lt_q, lt_d;
   logic          eq_q, eq_d;
   logic          gt_q, gt_d;

   // Every chunk is presented CW+1 bits wide; lower chunks get a zero MSB so
   // the single comparator handles them as unsigned.
   logic [CW:0] cha [NCHUNK];
   logic [CW:0] chb [NCHUNK];

   for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      if (gi == NCHUNK - 1) begin : g_top
         assign cha[gi] = xa_q[DW:DW-CW];
         assign chb[gi] = xb_q[DW:DW-CW];
      end else begin : g_low
         assign cha[gi] = {1'b0, xa_q[gi*CW +: CW]};
         assign chb[gi] = {1'b0, xb_q[gi*CW +: CW]};
      end
   end

   logic c_lt, c_eq, c_gt;
   logic idx_top;

   assign idx_top = (idx_q == IW'(NCHUNK - 1));

   comp_chunk_cmp #(.W(CW + 1)) u_chunk (
      .a_i          (cha[idx_q]),
      .b_i          (chb[idx_q]),
      .signed_top_i (idx_top),
      .lt_o         (c_lt),
      .eq_o         (c_eq),
      .gt_o         (c_gt)
   );

   // State, operand and result registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         xa_q    <= '0;
         xb_q    <= '0;
         idx_q   <= IW'(NCHUNK - 1);
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         xa_q    <= xa_d;
         xb_q    <= xb_d;
         idx_q   <= idx_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
         gt_q    <= gt_d;
      end
   end

   // Next-state logic: accept, walk chunks downward, hold result until taken.
   always_comb begin
      state_d = state_q;
      xa_d    = xa_q;
      xb_d    = xb_q;
      idx_d   = idx_q;
      lt_d    = lt_q;
      eq_d    = eq_q;
      gt_d    = gt_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               xa_d    = {ext_msb(a[DW-1], ext), a};
               xb_d    = {ext_msb(b[DW-1], ext), b};
               idx_d   = IW'(NCHUNK - 1);
               state_d = CMP;
            end
         end
         CMP: begin
            if (!c_eq) begin
               lt_d    = c_lt;
               gt_d    = c_gt;
               eq_d    = 1'b0;
               state_d = DONE;
            end else if (idx_q == '0) begin
               lt_d    = 1'b0;
               gt_d    = 1'b0;
               eq_d    = 1'b1;
               state_d = DONE;
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign lt        = lt_q;
   assign eq        = eq_q;
   assign gt        = gt_q;

endmodule

// File: doc/comp_serial_cmp.md
Name: comp_serial_cmp

Overview:
- Consumer side of the 65-bit extended-operand format used by the compare path.
- Takes two 64-bit operands and a mode bit, and forms the 65-bit extended values internally:
  - ext=0: signed, so bit 64 is the copy of bit 63.
  - ext=1: unsigned, so bit 64 is 0.
- Compares the two extended values as signed 65-bit numbers, most-significant chunk first, and stops at the first chunk that differs.
- Sits between the ALU operand registers and the branch/flag logic, with valid/ready handshakes on both sides.

Parameters:
- DW, 64, operand width. Must be a multiple of CW.
- CW, 16, chunk width compared per cycle.
- NCHUNK, DW/CW (4), derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept a pair.
- a  in  DW  operand A.
- b  in  DW  operand B.
- ext  in  1  0 = signed compare, 1 = unsigned compare.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- lt  out  1  A < B.
- eq  out  1  A == B.
- gt  out  1  A > B.

Behaviour:
- **Clock and reset:** one clock, `clk`. Reset is synchronous and active-low (`rst_n`).
- **Reset values:** while rst_n=0 at a clk edge:
  - state=IDLE.
  - in_ready=1 (combinational from state).
  - out_valid=0.
  - lt/eq/gt=0.
  - chunk index=NCHUNK-1.
  - operand registers=0.
- **Reset mid-operation:** the in-flight compare is discarded and no result is produced.
- **Extension:**
  - xa = {~ext & a[DW-1], a}; xb likewise. Both are DW+1 bits.
  - The top chunk is bits [DW:DW-CW], which is CW+1 bits, and is compared as signed.
  - All lower chunks are CW bits and are compared as unsigned.
- **States:** IDLE, CMP, DONE.
- **IDLE:**
  - in_ready=1.
  - On in_valid=1: register xa and xb, set idx=NCHUNK-1, go to CMP.
- **CMP:** in_ready=0. Each cycle compares chunk idx of xa against xb.
  - If the chunks differ: set lt/gt from that chunk, with eq=0, and go to DONE.
  - If the chunks are equal and idx=0: set eq=1, lt=gt=0, and go to DONE.
  - Otherwise: idx=idx-1 and stay in CMP.
- **DONE:**
  - out_valid=1. lt/eq/gt are held stable, and exactly one of them is 1.
  - On out_ready=1: out_valid goes to 0 next cycle and state returns to IDLE.
  - in_ready stays 0 in DONE. There is no overlap of consecutive operations.
- **Latency:** measured from the accept edge to out_valid=1.
  - 2 cycles if the top chunk differs.
  - Up to NCHUNK+1 cycles (5) for equal operands or operands that differ only in chunk 0.
  - Result flags are registered and change only on entry to DONE.
- **Boundary conditions:**
  - a, b and ext are ignored when not accepted.
  - out_ready held 1 throughout gives a one-cycle DONE.
  - out_ready held low holds the result indefinitely.
  - in_valid asserted during CMP/DONE is not accepted and must be held by the upstream block.
  - Signed −2^63 vs 2^63−1 resolves in the top chunk.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, CMP=2'd1, DONE=2'd2.
  - default DW/CW values.
  - the extension rule as a function, so it is identical to the combinational extend path.
- One sub-module: comp_chunk_cmp.
  - Combinational compare of two W-bit chunks with a `signed_top` input.
  - Outputs lt/eq/gt.
  - Instantiated once; a mux selects the chunk by idx.

Test Plan:
- Signed top-chunk case, after reset release: a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, ext=0 -> lt=1, eq=gt=0, out_valid 2 cycles after accept.
- Same operands with ext=1 -> gt=1, 2 cycles.
- Equal operands: a=b=0x1234_5678_9ABC_DEF0 -> eq=1 after 5 cycles, with in_ready=0 for the whole operation.
- Difference only in the low chunk: a=0x5, b=0x3, ext=0 -> gt=1 after 5 cycles. Then a=0x8000_0000_0000_0000, b=0x7FFF_FFFF_FFFF_FFFF with ext=0 -> lt=1; with ext=1 -> gt=1.
- Backpressure and input hold-off:
  - Hold out_ready=0 for 4 cycles in DONE -> out_valid and flags stay stable.
  - in_valid held 1 with new operands is not accepted until the cycle after the out_ready handshake.
- Reset during CMP: drop rst_n for 1 cycle at CMP idx=2 -> next cycle state=IDLE, out_valid=0, flags=0, in_ready=1; no stale result appears.
